// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RV32I immediate decoder feeding a 2-entry FIFO; perf counters enabled by IMM_GEN_PERF_CNT_EN
module imm_gen_pipe #(
   parameter int XLEN     = 32,
   parameter int BYTE_OFS = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_imm,
   output logic [2:0]      out_fmt,
   output logic            out_illegal,
   input  logic            perf_clr,
   output logic [31:0]     cnt_total,
   output logic [15:0]     cnt_illegal
);
   localparam int EW = XLEN + 4;

   logic [6:0]      op;
   logic [11:0]     b_imm;
   logic [19:0]     j_imm;
   logic [XLEN-1:0] b_ext, j_ext, dec_imm;
   logic [2:0]      dec_fmt;
   logic            dec_ill;
   logic [EW-1:0]   mem_q [2];
   logic [EW-1:0]   mem_d [2];
   logic            rd_q, rd_d, wr_q, wr_d;
   logic [1:0]      occ_q, occ_d;
   logic            push, pop;

   assign op    = in_instr[6:0];
   assign b_imm = {in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8]};
   assign j_imm = {in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21]};
   assign b_ext = (BYTE_OFS != 0) ? XLEN'($signed({b_imm, 1'b0})) : XLEN'($signed(b_imm));
   assign j_ext = (BYTE_OFS != 0) ? XLEN'($signed({j_imm, 1'b0})) : XLEN'($signed(j_imm));

   // Combinational decode of the incoming instruction word
   always_comb begin
      dec_imm = '0;
      dec_fmt = 3'd7;
      dec_ill = 1'b0;
      case (op)
         7'b0010011, 7'b0000011, 7'b1100111: begin
            dec_fmt = 3'd1;
            dec_imm = (op == 7'b0010011 && in_instr[13:12] == 2'b01) ? XLEN'(in_instr[24:20])
                                                                     : XLEN'($signed(in_instr[31:20]));
         end
         7'b0100011: begin
            dec_fmt = 3'd2;
            dec_imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
         end
         7'b1100011: begin
            dec_fmt = 3'd3;
            dec_imm = b_ext;
         end
         7'b0110111, 7'b0010111: begin
            dec_fmt = 3'd4;
            dec_imm = XLEN'($signed({in_instr[31:12], 12'b0}));
         end
         7'b1101111: begin
            dec_fmt = 3'd5;
            dec_imm = j_ext;
         end
         7'b0110011: dec_fmt = 3'd0;
         default:    dec_ill = 1'b1;
      endcase
   end

   assign in_ready  = occ_q != 2'd2;
   assign out_valid = occ_q != 2'd0;
   assign push      = in_valid && in_ready && !flush;
   assign pop       = out_valid && out_ready && !flush;
   assign {out_illegal, out_fmt, out_imm} = out_valid ? mem_q[rd_q] : '0;

   // FIFO next state; flush wins over push and pop
   always_comb begin
      mem_d = mem_q;
      if (push) mem_d[wr_q] = {dec_ill, dec_fmt, dec_imm};
      wr_d  = flush ? 1'b0 : wr_q ^ push;
      rd_d  = flush ? 1'b0 : rd_q ^ pop;
      occ_d = flush ? 2'd0 : occ_q + {1'b0, push} - {1'b0, pop};
   end

   // FIFO state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         occ_q    <= 2'd0;
      end else begin
         mem_q <= mem_d;
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         occ_q <= occ_d;
      end
   end

`ifdef IMM_GEN_PERF_CNT_EN
   logic [31:0] tot_q, tot_d;
   logic [15:0] ill_q, ill_d;

   // Saturating delivery counters; clear has priority
   always_comb begin
      tot_d = perf_clr ? '0 : (pop && !(&tot_q)) ? tot_q + 32'd1 : tot_q;
      ill_d = perf_clr ? '0 : (pop && out_illegal && !(&ill_q)) ? ill_q + 16'd1 : ill_q;
   end

   // Counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tot_q <= '0;
         ill_q <= '0;
      end else begin
         tot_q <= tot_d;
         ill_q <= ill_d;
      end
   end

   assign cnt_total   = tot_q;
   assign cnt_illegal = ill_q;
`else
   logic perf_clr_unused;
   assign perf_clr_unused = perf_clr;
   assign cnt_total       = '0;
   assign cnt_illegal     = '0;
`endif
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed and random checks of imm_gen_pipe against a queue-based reference model
module tb_imm_gen_pipe;
   typedef struct packed {
      logic [31:0] imm1;
      logic [31:0] imm0;
      logic [2:0]  fmt;
      logic        ill;
   } ent_t;

   logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0, perf_clr = 1'b0;
   logic [31:0] in_instr = '0;
   logic        in_ready, out_valid, out_illegal, in_ready_h, out_valid_h, out_illegal_h;
   logic [31:0] out_imm, out_imm_h, cnt_total, cnt_total_h;
   logic [2:0]  out_fmt, out_fmt_h;
   logic [15:0] cnt_illegal, cnt_illegal_h;

   int          checks = 0, failures = 0;
   ent_t        q[$];
   logic [31:0] exp_tot = '0;
   logic [15:0] exp_ill = '0;

   imm_gen_pipe #(.XLEN(32), .BYTE_OFS(1)) u_dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
      .out_fmt(out_fmt), .out_illegal(out_illegal), .perf_clr(perf_clr),
      .cnt_total(cnt_total), .cnt_illegal(cnt_illegal));

   imm_gen_pipe #(.XLEN(32), .BYTE_OFS(0)) u_half (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_h),
      .in_instr(in_instr), .out_valid(out_valid_h), .out_ready(out_ready), .out_imm(out_imm_h),
      .out_fmt(out_fmt_h), .out_illegal(out_illegal_h), .perf_clr(perf_clr),
      .cnt_total(cnt_total_h), .cnt_illegal(cnt_illegal_h));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic ent_t decode(input logic [31:0] i);
      ent_t e;
      int   v;
      logic bj;
      e  = '0;
      v  = 0;
      bj = 1'b0;
      case (i[6:0])
         7'b0010011, 7'b0000011, 7'b1100111: begin
            e.fmt = 3'd1;
            if (i[6:0] == 7'b0010011 && (i[14:12] == 3'd1 || i[14:12] == 3'd5)) v = int'(i[24:20]);
            else v = $signed(i) >>> 20;
         end
         7'b0100011: begin
            e.fmt = 3'd2;
            v = (($signed(i) >>> 25) * 32) + int'(i[11:7]);
         end
         7'b1100011: begin
            e.fmt = 3'd3;
            bj = 1'b1;
            v = (i[31] ? -2048 : 0) + int'(i[7]) * 1024 + int'(i[30:25]) * 16 + int'(i[11:8]);
         end
         7'b0110111, 7'b0010111: begin
            e.fmt = 3'd4;
            v = int'(i & 32'hFFFFF000);
         end
         7'b1101111: begin
            e.fmt = 3'd5;
            bj = 1'b1;
            v = (i[31] ? -524288 : 0) + int'(i[19:12]) * 2048 + int'(i[20]) * 1024 + int'(i[30:21]);
         end
         7'b0110011: e.fmt = 3'd0;
         default: begin
            e.fmt = 3'd7;
            e.ill = 1'b1;
         end
      endcase
      e.imm0 = v;
      e.imm1 = bj ? v * 2 : v;
      return e;
   endfunction

   task automatic check_outputs();
      chk("in_ready", in_ready, q.size() != 2);
      chk("out_valid", out_valid, q.size() != 0);
      chk("out_valid_h", out_valid_h, q.size() != 0);
      if (q.size() != 0) begin
         chk("out_imm", out_imm, q[0].imm1);
         chk("out_imm_h", out_imm_h, q[0].imm0);
         chk("out_fmt", out_fmt, q[0].fmt);
         chk("out_illegal", out_illegal, q[0].ill);
      end else begin
         chk("idle_imm", out_imm, 0);
         chk("idle_fmt", out_fmt, 0);
         chk("idle_illegal", out_illegal, 0);
      end
      chk("cnt_total", cnt_total, exp_tot);
      chk("cnt_illegal", cnt_illegal, exp_ill);
   endtask

   task automatic step(input logic v, input logic [31:0] i, input logic r, input logic f, input logic pc);
      logic do_push, do_pop, pop_ill;
      in_valid  = v;
      in_instr  = i;
      out_ready = r;
      flush     = f;
      perf_clr  = pc;
      #1;
      check_outputs();
      do_push = v && q.size() < 2 && !f;
      do_pop  = q.size() > 0 && r && !f;
      pop_ill = do_pop && q[0].ill;
      @(posedge clk);
`ifdef IMM_GEN_PERF_CNT_EN
      if (pc) begin
         exp_tot = '0;
         exp_ill = '0;
      end else begin
         if (do_pop && exp_tot != 32'hFFFFFFFF) exp_tot++;
         if (pop_ill && exp_ill != 16'hFFFF) exp_ill++;
      end
`endif
      if (f) q.delete();
      else begin
         if (do_pop) void'(q.pop_front());
         if (do_push) q.push_back(decode(i));
      end
      #1;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [6:0]  ops [10];
      logic [31:0] w;
      ops = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011, 7'b1100011,
              7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011, 7'b0001111};
      w = $urandom;
      if ($urandom_range(0, 9) != 0) w[6:0] = ops[$urandom_range(0, 9)];
      return w;
   endfunction

   initial begin
      #1;
      check_outputs();
      @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk);
      #1;
      step(1, 32'hFFF00093, 1, 0, 0);
      chk("addi_imm", out_imm, 32'hFFFFFFFF);
      chk("addi_fmt", out_fmt, 1);
      step(1, 32'hFE000EE3, 1, 0, 0);
      chk("beq_imm_byte", out_imm, 32'hFFFFFFFC);
      chk("beq_imm_half", out_imm_h, 32'hFFFFFFFE);
      chk("beq_fmt", out_fmt, 3);
      step(1, 32'h123450B7, 1, 0, 0);
      chk("lui_imm", out_imm, 32'h12345000);
      chk("lui_fmt", out_fmt, 4);
      step(1, 32'h01F09093, 1, 0, 0);
      chk("slli_imm", out_imm, 32'h0000001F);
      chk("slli_fmt", out_fmt, 1);
      step(0, 0, 1, 0, 0);
      step(1, 32'h00A00113, 0, 0, 0);
      step(1, 32'h00112223, 0, 0, 0);
      chk("full_in_ready", in_ready, 0);
      step(1, 32'h008000EF, 0, 0, 0);
      step(1, 32'h008000EF, 0, 0, 0);
      chk("held_imm", out_imm, 32'h0000000A);
      step(1, 32'h008000EF, 1, 0, 0);
      step(1, 32'h008000EF, 1, 0, 0);
      chk("third_imm", out_imm, 32'h00000008);
      step(0, 0, 1, 0, 0);
      step(1, 32'h0000007F, 0, 0, 0);
      chk("ill_fmt", out_fmt, 7);
      chk("ill_flag", out_illegal, 1);
      step(1, 32'h00000033, 1, 0, 0);
      chk("r_fmt", out_fmt, 0);
      step(0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0);
      step(1, 32'h00100093, 0, 0, 0);
      step(1, 32'h00200093, 0, 0, 0);
      step(1, 32'h00300093, 1, 1, 0);
      chk("flush_valid", out_valid, 0);
      chk("flush_ready", in_ready, 1);
      step(1, 32'h00400093, 0, 0, 0);
      step(1, 32'h00500093, 0, 0, 0);
      #2 rst = 1'b1;
      #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_ready", in_ready, 1);
      chk("rst_imm", out_imm, 0);
      chk("rst_cnt", cnt_total, 0);
      q.delete();
      exp_tot = '0;
      exp_ill = '0;
      @(posedge clk);
      #1 rst = 1'b0;
      for (int n = 0; n < 400; n++)
         step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 2) != 0,
              $urandom_range(0, 31) == 0, $urandom_range(0, 31) == 0);
      step(0, 0, 1, 0, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
